// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and constants for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf = 6'b000011;
  localparam logic [5:0] StallMem = 6'b011111;
  localparam logic [31:0] ZeroWord = 32'h0;
endpackage

// File: rtl/mem_arbiter_bus_wdog.sv
// bus_wdog: counts busy cycles without a bus ack and flags the abort cycle
module bus_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = en && (cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [5:0]  stall,
  output logic        bus_err
);
  import mem_arbiter_pkg::*;
  state_t state;
  logic discard, expired, done;
  assign done = bus_ack || expired;
  assign bus_req = state != IDLE;
  assign stall = (mem_req && !mem_ack) ? StallMem : (if_req && !if_ack) ? StallIf : StallNone;
  bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en(bus_req && !bus_ack),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      bus_we <= 1'b0;
      bus_addr <= ZeroWord;
      bus_wdata <= ZeroWord;
      bus_sel <= 4'h0;
      if_ack <= 1'b0;
      mem_ack <= 1'b0;
      if_rdata <= ZeroWord;
      mem_rdata <= ZeroWord;
      bus_err <= 1'b0;
      discard <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (mem_req) begin
            state <= MEM_BUSY;
            bus_we <= mem_we;
            bus_addr <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_sel <= mem_sel;
          end else if (if_req && !flush) begin
            state <= IF_BUSY;
            bus_we <= 1'b0;
            bus_addr <= if_addr;
            bus_wdata <= ZeroWord;
            bus_sel <= 4'hf;
          end
        end
        IF_BUSY: begin
          discard <= (discard || flush) && !done;
          if (done) begin
            state <= IDLE;
            bus_err <= expired;
            if (!(discard || flush)) begin
              if_ack <= 1'b1;
              if_rdata <= expired ? ZeroWord : bus_rdata;
            end
          end
        end
        MEM_BUSY:
          if (done) begin
            state <= IDLE;
            bus_err <= expired;
            mem_ack <= 1'b1;
            mem_rdata <= expired ? ZeroWord : bus_we ? mem_rdata : bus_rdata;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard-driven bench for the fetch/data memory arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 0, rst = 1;
  logic if_req = 0, mem_req = 0, mem_we = 0, flush = 0, bus_ack = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, bus_rdata = 0;
  logic [3:0] mem_sel = 0;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic if_ack, mem_ack, bus_req, bus_we, bus_err;
  logic [3:0] bus_sel;
  logic [5:0] stall;
  int checks = 0, failures = 0;
  logic [32:0] if_q[$], mem_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(stall),
    .bus_err(bus_err)
  );

  // Scoreboard: every requester ack must match the oldest expected {bus_err, rdata}
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (if_ack) begin
      checks++;
      if (if_q.size() == 0) begin
        failures++;
        $display("FAIL if_ack_unexpected got rdata=%h err=%b", if_rdata, bus_err);
      end else begin
        e = if_q.pop_front();
        if ({bus_err, if_rdata} !== e) begin
          failures++;
          $display("FAIL if_resp got err/rdata=%h exp=%h", {bus_err, if_rdata}, e);
        end
      end
    end
    if (mem_ack) begin
      checks++;
      if (mem_q.size() == 0) begin
        failures++;
        $display("FAIL mem_ack_unexpected got rdata=%h err=%b", mem_rdata, bus_err);
      end else begin
        e = mem_q.pop_front();
        if ({bus_err, mem_rdata} !== e) begin
          failures++;
          $display("FAIL mem_resp got err/rdata=%h exp=%h", {bus_err, mem_rdata}, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 0;
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel, if_ack, mem_ack, if_rdata, mem_rdata, bus_err, stall} !== '0) begin
      failures++;
      $display("FAIL reset_state got req=%b we=%b addr=%h sel=%h ifd=%h memd=%h err=%b stall=%b exp all zero",
               bus_req, bus_we, bus_addr, bus_sel, if_rdata, mem_rdata, bus_err, stall);
    end
    cyc();
    rst = 1;
  endtask

  task automatic test_if_fetch();
    cyc();
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (stall !== StallIf || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL if_request_cycle got stall=%b req=%b exp stall=%b req=0", stall, bus_req, StallIf);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 3) begin
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        if_q.push_back({1'b0, 32'hDEADBEEF});
      end
      @(negedge clk);
      checks++;
      if ({bus_req, bus_we, bus_sel, bus_addr, stall} !== {1'b1, 1'b0, 4'hf, 32'h100, StallIf}) begin
        failures++;
        $display("FAIL if_busy%0d got req=%b we=%b sel=%h addr=%h stall=%b", i, bus_req, bus_we, bus_sel, bus_addr, stall);
      end
    end
    cyc();
    bus_ack = 0; if_req = 0;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL if_complete got ack=%b req=%b exp ack=1 req=0", if_ack, bus_req);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL if_ack_pulse got ack=%b rdata=%h exp ack=0 rdata=deadbeef", if_ack, if_rdata);
    end
  endtask

  task automatic test_priority();
    cyc();
    if_req = 1; if_addr = 32'h300;
    mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hf;
    @(negedge clk);
    checks++;
    if (stall !== StallMem) begin
      failures++;
      $display("FAIL prio_stall got %b exp %b", stall, StallMem);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h200}) begin
      failures++;
      $display("FAIL prio_mem_first got req=%b we=%b addr=%h exp 1/0/200", bus_req, bus_we, bus_addr);
    end
    cyc();
    bus_ack = 1; bus_rdata = 32'hCAFE0001;
    mem_q.push_back({1'b0, 32'hCAFE0001});
    cyc();
    bus_ack = 0; mem_req = 0;
    @(negedge clk);
    checks++;
    if (mem_ack !== 1'b1 || bus_req !== 1'b0 || stall !== StallIf) begin
      failures++;
      $display("FAIL prio_idle_gap got mem_ack=%b req=%b stall=%b exp 1/0/%b", mem_ack, bus_req, stall, StallIf);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin
      failures++;
      $display("FAIL prio_if_second got req=%b addr=%h exp 1/300", bus_req, bus_addr);
    end
    cyc();
    bus_ack = 1; bus_rdata = 32'h11112222;
    if_q.push_back({1'b0, 32'h11112222});
    cyc();
    bus_ack = 0; if_req = 0;
  endtask

  task automatic test_store();
    cyc();
    mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_wdata = 32'h1234; mem_addr = 32'h400;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      mem_wdata = 32'hFFFF; mem_sel = 4'hf; mem_addr = 32'h0;
      if (i == 3) begin
        bus_ack = 1; bus_rdata = 32'h99999999;
        mem_q.push_back({1'b0, 32'hCAFE0001});
      end
      @(negedge clk);
      checks++;
      if ({bus_req, bus_we, bus_sel, bus_wdata, bus_addr} !== {1'b1, 1'b1, 4'b0011, 32'h1234, 32'h400}) begin
        failures++;
        $display("FAIL store_busy%0d got req=%b we=%b sel=%b wdata=%h addr=%h", i, bus_req, bus_we, bus_sel, bus_wdata, bus_addr);
      end
    end
    cyc();
    bus_ack = 0; mem_req = 0; mem_we = 0;
  endtask

  task automatic test_timeout(input bit ack_last);
    cyc();
    mem_req = 1; mem_addr = 32'h500; mem_sel = 4'hf;
    mem_q.push_back(ack_last ? {1'b0, 32'h55AA55AA} : {1'b1, 32'h0});
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (ack_last && i == 4) begin bus_ack = 1; bus_rdata = 32'h55AA55AA; end
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b1) begin
        failures++;
        $display("FAIL timeout_busy%0d got req=%b exp 1", i, bus_req);
      end
    end
    cyc();
    bus_ack = 0; mem_req = 0;
    @(negedge clk);
    checks++;
    if ({bus_req, mem_ack, bus_err} !== {1'b0, 1'b1, !ack_last}) begin
      failures++;
      $display("FAIL timeout_end ack_last=%0d got req=%b ack=%b err=%b exp 0/1/%b", ack_last, bus_req, mem_ack, bus_err, !ack_last);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || mem_ack !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got err=%b ack=%b exp 0/0", bus_err, mem_ack);
    end
  endtask

  task automatic test_flush();
    cyc();
    if_req = 1; if_addr = 32'h600;
    cyc();
    flush = 1;
    cyc();
    flush = 0;
    cyc();
    bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
    cyc();
    bus_ack = 0; if_addr = 32'h700;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h11112222 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard got ack=%b rdata=%h req=%b exp 0/11112222/0", if_ack, if_rdata, bus_req);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h700) begin
      failures++;
      $display("FAIL flush_next_fetch got req=%b addr=%h exp 1/700", bus_req, bus_addr);
    end
    cyc();
    bus_ack = 1; bus_rdata = 32'h00000077;
    if_q.push_back({1'b0, 32'h00000077});
    cyc();
    bus_ack = 0; if_req = 0;
  endtask

  task automatic test_reset_mid();
    cyc();
    mem_req = 1; mem_addr = 32'h800;
    cyc();
    cyc();
    rst = 0;
    #1;
    checks++;
    if ({bus_req, bus_addr, bus_sel, mem_ack, mem_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid got req=%b addr=%h sel=%h ack=%b rdata=%h exp zero", bus_req, bus_addr, bus_sel, mem_ack, mem_rdata);
    end
    mem_req = 0;
    cyc();
    rst = 1; bus_ack = 1; bus_rdata = 32'hEEEEEEEE;
    cyc();
    bus_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b0 || mem_ack !== 1'b0 || bus_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_abandon%0d got req=%b ack=%b err=%b exp 0", i, bus_req, mem_ack, bus_err);
      end
      cyc();
    end
  endtask

  task automatic test_first_grant();
    rst = 0; mem_req = 1; mem_addr = 32'h900;
    @(negedge clk);
    cyc();
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      failures++;
      $display("FAIL first_grant_early got req=%b exp 0", bus_req);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h900) begin
      failures++;
      $display("FAIL first_grant got req=%b addr=%h exp 1/900", bus_req, bus_addr);
    end
    cyc();
    bus_ack = 1; bus_rdata = 32'h0000900D;
    mem_q.push_back({1'b0, 32'h0000900D});
    cyc();
    bus_ack = 0; mem_req = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_priority();
    test_store();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_flush();
    test_reset_mid();
    test_first_grant();
    repeat (2) cyc();
    checks++;
    if (if_q.size() != 0 || mem_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got if_left=%0d mem_left=%0d exp 0/0", if_q.size(), mem_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got time=%0t exp finish earlier", $time);
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning bus-ack cycles to wait before abort (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1; if_addr  in  32  instruction-fetch request and address.
REQ-005 if_rdata  out  32; if_ack  out  1  fetch data and one-cycle completion pulse.
REQ-006 mem_req  in  1; mem_we  in  1; mem_addr  in  32; mem_wdata  in  32; mem_sel  in  4  data-access request from MEM stage.
REQ-007 mem_rdata  out  32; mem_ack  out  1  load data and one-cycle completion pulse.
REQ-008 flush  in  1  pipeline flush; cancels fetch results.
REQ-009 bus_req  out  1; bus_we  out  1; bus_addr  out  32; bus_wdata  out  32; bus_sel  out  4  single shared memory port.
REQ-010 bus_rdata  in  32; bus_ack  in  1  bus completion; rdata valid in the ack cycle.
REQ-011 stall  out  6  pipeline stall vector, bit0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb.
REQ-012 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-013 FSM states IDLE, IF_BUSY, MEM_BUSY; exactly one bus transaction outstanding at any time.
REQ-014 IDLE: mem_req -> MEM_BUSY; else if_req and not flush -> IF_BUSY; else stay IDLE; MEM has fixed priority.
REQ-015 On grant, requester address/data/we/sel are latched; bus_* outputs are driven from latches, stable until bus_ack or timeout.
REQ-016 bus_req is 1 exactly while in IF_BUSY or MEM_BUSY; bus_we=0 and bus_sel=4'b1111 in IF_BUSY.
REQ-017 Latency: request seen at edge N -> bus_req high from cycle N+1; bus_ack at cycle M -> FSM returns to IDLE at M+1, requester ack pulse and rdata registered at M+1.
REQ-018 After each completion the FSM spends one cycle in IDLE before the next grant (no back-to-back grants).
REQ-019 if_rdata/mem_rdata hold their last value until the next ack of the same requester; a store ack leaves mem_rdata unchanged.
REQ-020 Timeout counter clears on grant, increments each busy cycle without bus_ack; on reaching TIMEOUT: bus_req drops, FSM -> IDLE, requester ack pulses with rdata=32'h0, bus_err pulses once.
REQ-021 bus_ack in the same cycle the counter reaches TIMEOUT counts as normal completion; bus_err stays 0.
REQ-022 flush during IF_BUSY sets a discard flag: transaction still runs to completion, if_ack suppressed, if_rdata unchanged; flag clears on return to IDLE.
REQ-023 flush during MEM_BUSY is ignored; the data access completes and mem_ack is issued.
REQ-024 stall (combinational from state and inputs): mem_req high and mem_ack low -> 6'b011111; else if_req high and if_ack low -> 6'b000011; else 6'b000000.
REQ-025 bus_ack while IDLE is ignored.

Reset
REQ-026 rst low asynchronously forces: FSM=IDLE, bus_req=0, bus_we=0, bus_addr/bus_wdata=0, bus_sel=0, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, bus_err=0, counter=0, discard flag=0.
REQ-027 Reset mid-transaction abandons it; no ack or bus_err is issued for it after release.
REQ-028 First grant possible at the first rising edge after rst deasserts.

Structure
REQ-029 State encodings, stall-vector constants (StallNone, StallIf, StallMem) and ZeroWord live in the shared defines include.
REQ-030 One sub-module, bus_wdog: timeout counter with clear/enable inputs and expired output, TIMEOUT parameter passed through.

Verification
REQ-031 IF only: if_req=1 addr 0x100, bus_ack at 3rd busy cycle with rdata 0xDEADBEEF -> if_ack one cycle later, if_rdata=0xDEADBEEF, stall=000011 until then.
REQ-032 Simultaneous if_req and mem_req (load 0x200) -> MEM granted first, stall=011111, IF granted after mem_ack plus one IDLE cycle.
REQ-033 Store: mem_we=1, sel=4'b0011, wdata 0x1234 -> bus_we=1, bus_sel=0011 held stable until ack; mem_rdata unchanged.
REQ-034 TIMEOUT=4, no bus_ack -> bus_req drops after 4 busy cycles, bus_err and mem_ack pulse together, mem_rdata=0.
REQ-035 flush in IF_BUSY, ack 2 cycles later -> no if_ack, if_rdata unchanged, next fetch granted normally.
REQ-036 rst low mid MEM_BUSY -> bus_req 0 immediately, no mem_ack after release.
